// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - trace window geometry, FSM states, span entry type and sample mapper
package wave_pkg;

  localparam int WAVE_W  = 500;
  localparam int WAVE_X0 = 100;
  localparam int WAVE_Y0 = 100;
  localparam int WAVE_H  = 256;
  localparam int V_SHIFT = 4;
  localparam int RD_LAT  = 1;
  localparam int COL_W   = $clog2(WAVE_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FLUSH,
    ST_DONE
  } wave_state_e;

  typedef struct packed {
    logic        valid;
    logic [10:0] y_lo;
    logic [10:0] y_hi;
  } span_t;

  // Larger samples land higher on screen; the shifted value is clamped to the window height.
  function automatic logic [10:0] sample_to_row(input logic [11:0] s);
    logic [11:0] sh;
    sh = s >> V_SHIFT;
    if (sh > 12'(WAVE_H - 1)) sh = 12'(WAVE_H - 1);
    return 11'(WAVE_Y0 + WAVE_H - 1) - 11'(sh);
  endfunction

endpackage

// File: rtl/wave_draw_if.sv
// rtl/wave_draw_if.sv - sample store read bus between the trace drawer and the capture store
interface wave_draw_if;

  logic        wave_data_req;
  logic [9:0]  wave_rd_addr;
  logic [11:0] wave_rd_data;
  logic        outrange;
  logic        lcd_wr_over;

  modport master (
    output wave_data_req,
    output wave_rd_addr,
    output lcd_wr_over,
    input  wave_rd_data,
    input  outrange
  );

  modport slave (
    input  wave_data_req,
    input  wave_rd_addr,
    input  lcd_wr_over,
    output wave_rd_data,
    output outrange
  );

endinterface

// File: rtl/wave_col_buf.sv
// rtl/wave_col_buf.sv - per-column span table, one write port and one registered read port
module wave_col_buf
  import wave_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [COL_W-1:0] waddr,
  input  span_t            wdata,
  input  logic [COL_W-1:0] raddr,
  output span_t            rdata
);

  // Valid bits live in flops so reset can invalidate every column at once.
  logic [21:0]       mem [WAVE_W];
  logic [WAVE_W-1:0] valid_q;
  logic [21:0]       rd_yy;
  logic              rd_v;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {wdata.y_lo, wdata.y_hi};
    rd_yy <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rd_v    <= 1'b0;
    end else begin
      if (we) valid_q[waddr] <= wdata.valid;
      rd_v <= valid_q[raddr];
    end
  end

  assign rdata.valid = rd_v;
  assign rdata.y_lo  = rd_yy[21:11];
  assign rdata.y_hi  = rd_yy[10:0];

endmodule

// File: rtl/wave_draw.sv
// rtl/wave_draw.sv - vertical-blank sample fetch into a span table and active-video trace hit test
module wave_draw (
  input  logic        lcd_clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        wave_run,
  wave_draw_if.master store,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  output logic        wave_pixel
);
  import wave_pkg::*;

  localparam logic [9:0]  LAST_ADDR = 10'(WAVE_W - 1);
  localparam logic [3:0]  LAST_WAIT = 4'(RD_LAT - 1);
  localparam logic [10:0] X_LO      = 11'(WAVE_X0);
  localparam logic [10:0] X_HI      = 11'(WAVE_X0 + WAVE_W);

  wave_state_e      state, state_nxt;
  logic [9:0]       addr_q;
  logic [3:0]       flush_cnt;
  logic             fetch_req;
  logic             over_q;

  logic [RD_LAT-1:0] tag_v;
  logic [COL_W-1:0]  tag_c [RD_LAT];
  logic              ret_v;
  logic [COL_W-1:0]  ret_col;

  logic [10:0]      y_new;
  logic [10:0]      y_prev;
  logic             prev_v;
  span_t            span_w;

  logic             in_win;
  logic [COL_W-1:0] rd_col;
  span_t            rd_span;
  logic [10:0]      y_d;
  logic             win_d;

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fetch_req = 1'b0;
    case (state)
      ST_IDLE:  if (frame_start && wave_run) state_nxt = ST_FETCH;
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (addr_q == LAST_ADDR) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: if (flush_cnt == LAST_WAIT) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The address counter parks at zero outside FETCH, so a sweep always starts at column 0.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      flush_cnt <= '0;
      over_q    <= 1'b0;
    end else begin
      if (state == ST_FETCH && addr_q != LAST_ADDR) addr_q <= addr_q + 10'd1;
      else                                          addr_q <= '0;
      if (state == ST_FLUSH) flush_cnt <= flush_cnt + 4'd1;
      else                   flush_cnt <= '0;
      if (state_nxt == ST_FETCH && state != ST_FETCH) over_q <= 1'b0;
      else if (state_nxt == ST_DONE)                  over_q <= 1'b1;
    end
  end

  assign store.wave_data_req = fetch_req;
  assign store.wave_rd_addr  = addr_q;
  assign store.lcd_wr_over   = over_q;

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_c[i] <= '0;
    end else begin
      tag_v[0] <= fetch_req;
      tag_c[0] <= addr_q[COL_W-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_c[i] <= tag_c[i-1];
      end
    end
  end

  assign ret_v   = tag_v[RD_LAT-1];
  assign ret_col = tag_c[RD_LAT-1];
  assign y_new   = sample_to_row(store.wave_rd_data);

  // Each column spans from its own row to the previous valid row so steep edges stay connected.
  always_comb begin
    span_w = '0;
    if (!store.outrange) begin
      span_w.valid = 1'b1;
      if (ret_col == '0 || !prev_v) begin
        span_w.y_lo = y_new;
        span_w.y_hi = y_new;
      end else begin
        span_w.y_lo = (y_new < y_prev) ? y_new : y_prev;
        span_w.y_hi = (y_new < y_prev) ? y_prev : y_new;
      end
    end
  end

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
      y_prev <= '0;
    end else if (ret_v) begin
      prev_v <= !store.outrange;
      if (!store.outrange) y_prev <= y_new;
    end
  end

  wave_col_buf u_col_buf (
    .clk   (lcd_clk),
    .rst_n (rst_n),
    .we    (ret_v),
    .waddr (ret_col),
    .wdata (span_w),
    .raddr (rd_col),
    .rdata (rd_span)
  );

  assign in_win = (pixel_x >= X_LO) && (pixel_x < X_HI);
  assign rd_col = in_win ? COL_W'(pixel_x - X_LO) : '0;

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      y_d        <= '0;
      win_d      <= 1'b0;
      wave_pixel <= 1'b0;
    end else begin
      y_d        <= pixel_y;
      win_d      <= in_win;
      wave_pixel <= win_d && rd_span.valid &&
                    (rd_span.y_lo <= y_d) && (y_d <= rd_span.y_hi);
    end
  end

endmodule

// File: tb/tb_wave_draw.sv
// tb/tb_wave_draw.sv - directed bench for wave_draw sweep, span table and pixel hit test
module tb_wave_draw;

  logic        lcd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        wave_run = 1'b0;
  logic [10:0] pixel_x = '0;
  logic [10:0] pixel_y = '0;
  logic        wave_pixel;

  wave_draw_if sif ();

  always #5 lcd_clk = ~lcd_clk;

  wave_draw dut (
    .lcd_clk     (lcd_clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .wave_run    (wave_run),
    .store       (sif),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .wave_pixel  (wave_pixel)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int sw_reqs, sw_addr_ok, sw_gap, sw_bad_over, sw_killed;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sample_of(input int mode, input int a);
    if (mode == 1) return (a < 250) ? 0 : 4095;
    return 'h800;
  endfunction

  task automatic sweep(input int mode, input int drop_at, input int kill_at);
    int prev = -1;
    int last = -1;
    sw_reqs = 0; sw_addr_ok = 1; sw_gap = -1; sw_bad_over = 0; sw_killed = 0;
    @(negedge lcd_clk) frame_start = 1'b1;
    @(negedge lcd_clk) frame_start = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (prev >= 0) begin
        sif.wave_rd_data = 12'(sample_of(mode, prev));
        sif.outrange     = (mode == 2 && prev < 50);
      end
      prev = -1;
      if (cyc == drop_at) wave_run = 1'b0;
      frame_start = (cyc == 300);
      if (sif.wave_data_req) begin
        if (int'(sif.wave_rd_addr) != sw_reqs) sw_addr_ok = 0;
        if (sif.lcd_wr_over) sw_bad_over++;
        if (int'(sif.wave_rd_addr) == kill_at) begin
          rst_n = 1'b0;
          #1;
          check_eq("rst_mid_req",  int'(sif.wave_data_req), 0);
          check_eq("rst_mid_addr", int'(sif.wave_rd_addr), 0);
          check_eq("rst_mid_over", int'(sif.lcd_wr_over), 0);
          check_eq("rst_mid_pix",  int'(wave_pixel), 0);
          sw_killed = 1;
          frame_start = 1'b0;
          @(negedge lcd_clk) rst_n = 1'b1;
          return;
        end
        prev = int'(sif.wave_rd_addr);
        last = cyc;
        sw_reqs++;
      end else if (sw_reqs == 500 && sif.lcd_wr_over) begin
        sw_gap = cyc - last;
        break;
      end
      @(negedge lcd_clk);
    end
    frame_start = 1'b0;
  endtask

  task automatic check_sweep(input string tag);
    check_eq({tag, "_reqs"}, sw_reqs, 500);
    check_eq({tag, "_addr_seq"}, sw_addr_ok, 1);
    check_eq({tag, "_over_gap"}, sw_gap, 2);
    check_eq({tag, "_over_in_fetch"}, sw_bad_over, 0);
  endtask

  task automatic probe(input string tag, input int x, input int y, input int exp);
    @(negedge lcd_clk);
    pixel_x = 11'(x);
    pixel_y = 11'(y);
    @(negedge lcd_clk);
    pixel_x = '0;
    pixel_y = '0;
    @(negedge lcd_clk);
    check_eq(tag, int'(wave_pixel), exp);
  endtask

  task automatic idle_frame(input string tag, input int exp_over);
    int reqs = 0;
    @(negedge lcd_clk) frame_start = 1'b1;
    @(negedge lcd_clk) frame_start = 1'b0;
    repeat (20) begin
      if (sif.wave_data_req) reqs++;
      @(negedge lcd_clk);
    end
    check_eq({tag, "_req"}, reqs, 0);
    check_eq({tag, "_over"}, int'(sif.lcd_wr_over), exp_over);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sif.wave_rd_data = '0;
    sif.outrange     = 1'b0;
    repeat (3) @(negedge lcd_clk);
    check_eq("reset_req",  int'(sif.wave_data_req), 0);
    check_eq("reset_addr", int'(sif.wave_rd_addr), 0);
    check_eq("reset_over", int'(sif.lcd_wr_over), 0);
    check_eq("reset_pix",  int'(wave_pixel), 0);
    rst_n = 1'b1;
    wave_run = 1'b1;
    probe("empty_table", 100, 227, 0);

    sweep(0, -1, -1);
    check_sweep("const");
    probe("const_100_227", 100, 227, 1);
    probe("const_599_227", 599, 227, 1);
    probe("const_99_227",  99,  227, 0);
    probe("const_600_227", 600, 227, 0);
    probe("const_100_226", 100, 226, 0);
    probe("const_100_228", 100, 228, 0);

    sweep(1, -1, -1);
    check_sweep("step");
    probe("step_350_200", 350, 200, 1);
    probe("step_349_355", 349, 355, 1);
    probe("step_349_354", 349, 354, 0);
    probe("step_351_200", 351, 200, 0);
    probe("step_351_100", 351, 100, 1);

    sweep(2, -1, -1);
    check_sweep("orange");
    probe("orange_100_227", 100, 227, 0);
    probe("orange_149_227", 149, 227, 0);
    probe("orange_150_227", 150, 227, 1);
    probe("orange_150_150", 150, 150, 0);

    wave_run = 1'b0;
    idle_frame("run0", 1);
    probe("run0_keep", 150, 227, 1);

    wave_run = 1'b1;
    sweep(0, 100, -1);
    check_eq("drop_reqs", sw_reqs, 500);
    check_eq("drop_addr_seq", sw_addr_ok, 1);
    idle_frame("after_drop", 1);
    probe("drop_table", 100, 227, 1);

    wave_run = 1'b1;
    sweep(1, -1, 200);
    check_eq("kill_reached", sw_killed, 1);
    probe("kill_100_227", 100, 227, 0);
    probe("kill_100_355", 100, 355, 0);
    probe("kill_350_200", 350, 200, 0);
    wave_run = 1'b0;
    idle_frame("post_rst", 0);

    wave_run = 1'b1;
    sweep(0, -1, -1);
    check_sweep("resweep");
    probe("resweep_100_227", 100, 227, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
